abm_chan_config: RTL

ABM_CHAN_CONFIG -- requirements
Module: abm_chan_config

---
 rtl/abm_cfg_pkg.sv | 28 ++
 rtl/abm_done_tracker.sv | 52 +++++
 rtl/abm_chan_config.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/abm_cfg_pkg.sv
// Shared definitions for the ABM channel configuration block: register
// indices, AXI response codes and the channel-count ceiling.
package abm_cfg_pkg;

  localparam int unsigned MAX_CHAN = 8;

  // Register index = AXI address bits [6:2]
  localparam logic [4:0] IDX_PCI_ADDRH  = 5'd0;
  localparam logic [4:0] IDX_PCI_ADDRL  = 5'd1;
  localparam logic [4:0] IDX_START      = 5'd2;
  localparam logic [4:0] IDX_IDLE       = 5'd3;
  localparam logic [4:0] IDX_DONE       = 5'd4;
  localparam logic [4:0] IDX_IRQ_ENABLE = 5'd5;
  localparam logic [4:0] IDX_CHAN_COUNT = 5'd6;
  localparam logic [4:0] IDX_CNT_BASE   = 5'd8;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  // True when idx addresses one of the num_chan counter registers
  function automatic logic is_cnt_idx(logic [4:0] idx, int unsigned num_chan);
    return (idx >= IDX_CNT_BASE) && (32'(idx) < 32'(IDX_CNT_BASE) + num_chan);
  endfunction

endpackage

// File: rtl/abm_done_tracker.sv
// Per-channel completion tracking: detects idle 0->1 edges, keeps a sticky
// write-1-to-clear done flag per channel and reduces enabled flags to one irq.
module abm_done_tracker #(
  parameter int unsigned NUM_CHAN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CHAN-1:0] idle,
  input  logic                clr_en,
  input  logic [NUM_CHAN-1:0] clr_mask,
  input  logic [NUM_CHAN-1:0] irq_en,
  output logic [NUM_CHAN-1:0] done,
  output logic                irq
);

  logic [NUM_CHAN-1:0] idle_q;
  logic [NUM_CHAN-1:0] done_q, done_d;
  logic                irq_q;

  // Previous idle; resets to ones so channels idle at reset release do not flag done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '1;
    end else begin
      idle_q <= idle;
    end
  end

  // Clear first, then OR in new rising edges so a same-cycle set wins
  always_comb begin
    done_d = done_q;
    if (clr_en) begin
      done_d = done_d & ~clr_mask;
    end
    done_d = done_d | (idle & ~idle_q);
  end

  // Sticky done flags and registered interrupt reduction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      irq_q  <= |(done_q & irq_en);
    end
  end

  assign done = done_q;
  assign irq  = irq_q;

endmodule

// File: rtl/abm_chan_config.sv
// AXI4-Lite register file configuring the ABM manager: PCI source address,
// per-channel start levels, idle status and counter readback.
// Optional build macro ABM_CFG_IRQ_EN adds DONE / IRQ_ENABLE registers and irq.
module abm_chan_config
  import abm_cfg_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [63:0]               pci_src_addr,
  output logic [NUM_CHAN-1:0]       start,
  output logic                      start_wstrobe,
  input  logic [NUM_CHAN-1:0]       idle,
  input  logic [NUM_CHAN*CNT_W-1:0] abm_counter,
  output logic                      irq,
  input  logic [31:0]               S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [31:0]               S_AXI_WDATA,
  input  logic [3:0]                S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [31:0]               S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [31:0]               S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  if ((NUM_CHAN < 1) || (NUM_CHAN > MAX_CHAN) || (CNT_W < 1) || (CNT_W > 32)) begin : g_bad_param
    $error("abm_chan_config: NUM_CHAN must be 1..8 and CNT_W 1..32");
  end

  // Handshake state
  logic      awready_q, awready_d;
  logic      bvalid_q, bvalid_d;
  axi_resp_e bresp_q, bresp_d;
  logic      arready_q, arready_d;
  logic      rvalid_q, rvalid_d;
  axi_resp_e rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  // Register state
  logic [31:0]         pci_hi_q, pci_lo_q;
  logic [NUM_CHAN-1:0] start_q;
  logic                strobe_q;

  // Decode
  logic [4:0]  wr_idx, rd_idx;
  logic        wr_fire, wr_ok, wr_en;
  logic        rd_fire, rd_hit;
  logic [31:0] rd_val;

  logic [NUM_CHAN-1:0] done;
  logic [NUM_CHAN-1:0] irq_en;

  assign wr_idx  = S_AXI_AWADDR[6:2];
  assign rd_idx  = S_AXI_ARADDR[6:2];
  // Ready flags are only raised while both valids are present, so the
  // qualification here just guards against a master dropping valid early.
  assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready_q & S_AXI_ARVALID;
  assign wr_en   = wr_fire & wr_ok;

  // Writable register decode
  always_comb begin
    wr_ok = 1'b0;
    case (wr_idx)
      IDX_PCI_ADDRH, IDX_PCI_ADDRL, IDX_START: wr_ok = 1'b1;
`ifdef ABM_CFG_IRQ_EN
      IDX_DONE, IDX_IRQ_ENABLE:                wr_ok = 1'b1;
`endif
      default:                                 wr_ok = 1'b0;
    endcase
  end

  // Readable register mux, evaluated against current state at acceptance
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    case (rd_idx)
      IDX_PCI_ADDRH: begin
        rd_hit = 1'b1;
        rd_val = pci_hi_q;
      end
      IDX_PCI_ADDRL: begin
        rd_hit = 1'b1;
        rd_val = pci_lo_q;
      end
      IDX_START: begin
        rd_hit = 1'b1;
        rd_val = 32'(start_q);
      end
      IDX_IDLE: begin
        rd_hit = 1'b1;
        rd_val = 32'(idle);
      end
`ifdef ABM_CFG_IRQ_EN
      IDX_DONE: begin
        rd_hit = 1'b1;
        rd_val = 32'(done);
      end
      IDX_IRQ_ENABLE: begin
        rd_hit = 1'b1;
        rd_val = 32'(irq_en);
      end
`endif
      IDX_CHAN_COUNT: begin
        rd_hit = 1'b1;
        rd_val = 32'(NUM_CHAN);
      end
      default: ;
    endcase
    if (is_cnt_idx(rd_idx, NUM_CHAN)) begin
      rd_hit = 1'b1;
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
        if (rd_idx == IDX_CNT_BASE + 5'(i)) begin
          rd_val = 32'(abm_counter[i*CNT_W +: CNT_W]);
        end
      end
    end
  end

  // Write channel next state: one-cycle ready pulse, response held until BREADY
  always_comb begin
    awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RespOkay : RespDecerr;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Read channel next state: one-cycle ready pulse, data held until RREADY
  always_comb begin
    arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_hit ? RespOkay : RespDecerr;
      rdata_d  = rd_hit ? rd_val : 32'h0;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // AXI handshake registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Configuration registers; start strobe pulses in the cycle start updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pci_hi_q <= '0;
      pci_lo_q <= '0;
      start_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= wr_en && (wr_idx == IDX_START);
      if (wr_en && (wr_idx == IDX_PCI_ADDRH)) pci_hi_q <= S_AXI_WDATA;
      if (wr_en && (wr_idx == IDX_PCI_ADDRL)) pci_lo_q <= S_AXI_WDATA;
      if (wr_en && (wr_idx == IDX_START))     start_q  <= S_AXI_WDATA[NUM_CHAN-1:0];
    end
  end

`ifdef ABM_CFG_IRQ_EN
  logic [NUM_CHAN-1:0] irq_en_q;

  // Interrupt enable mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= '0;
    end else if (wr_en && (wr_idx == IDX_IRQ_ENABLE)) begin
      irq_en_q <= S_AXI_WDATA[NUM_CHAN-1:0];
    end
  end

  assign irq_en = irq_en_q;

  abm_done_tracker #(
    .NUM_CHAN (NUM_CHAN)
  ) u_done_tracker (
    .clk      (clk),
    .reset    (reset),
    .idle     (idle),
    .clr_en   (wr_en && (wr_idx == IDX_DONE)),
    .clr_mask (S_AXI_WDATA[NUM_CHAN-1:0]),
    .irq_en   (irq_en),
    .done     (done),
    .irq      (irq)
  );
`else
  assign done   = '0;
  assign irq_en = '0;
  assign irq    = 1'b0;
`endif

  assign pci_src_addr  = {pci_hi_q, pci_lo_q};
  assign start         = start_q;
  assign start_wstrobe = strobe_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  // Address bits outside [6:2], protection and strobes carry no meaning here
  logic unused_sigs;
  assign unused_sigs = ^{S_AXI_AWADDR[31:7], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:7],
                         S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                         done, irq_en};

endmodule
